// File: rtl/logic_gate_sweeper_if.sv
// Bus between the lab gate unit and its switch/LED side: mode, inputs,
// sweep control and the captured truth table.
interface logic_gate_sweeper_if #(
  parameter int N_INPUTS = 3
);
  localparam int RESULT_W = 1 << N_INPUTS;

  logic [2:0]          gateMode;
  logic [N_INPUTS-1:0] manualIn;
  logic                start;
  logic                busy;
  logic                done;
  logic [N_INPUTS-1:0] sweepIn;
  logic                stage1Out;
  logic                gateOut;
  logic [RESULT_W-1:0] result;
  logic [N_INPUTS:0]   onesCount;

  modport master (
    output gateMode, manualIn, start,
    input  busy, done, sweepIn, stage1Out, gateOut, result, onesCount
  );

  modport slave (
    input  gateMode, manualIn, start,
    output busy, done, sweepIn, stage1Out, gateOut, result, onesCount
  );
endinterface

// File: rtl/logic_gate_sweeper.sv
// N-input gate evaluator: registered manual result plus a sequencer that captures
// the full truth table. Define ONES_COUNT_EN to enable the onesCount accumulator.
module logic_gate_sweeper #(
  parameter int N_INPUTS = 3
) (
  input logic                  clk,
  input logic                  resetN,
  logic_gate_sweeper_if.slave  bus
);
  localparam int RESULT_W = 1 << N_INPUTS;
  localparam int IDX_W    = N_INPUTS + 1;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  localparam logic [N_INPUTS-1:0] FULL_MASK  = '1;
  localparam logic [N_INPUTS-1:0] STAGE_MASK = {1'b0, {(N_INPUTS-1){1'b1}}};
  localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(RESULT_W - 1);

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    idx_reg;
  logic [2:0]          mode_reg;
  logic [RESULT_W-1:0] result_reg;
  logic [RESULT_W-1:0] table_vec;
  logic                gate_reg;
  logic                stage1_reg;

  // Masked-out bits are forced to the reduction's identity value.
  function automatic logic reduce_and(input logic [N_INPUTS-1:0] v, input logic [N_INPUTS-1:0] m);
    return &(v | ~m);
  endfunction

  function automatic logic reduce_or(input logic [N_INPUTS-1:0] v, input logic [N_INPUTS-1:0] m);
    return |(v & m);
  endfunction

  function automatic logic reduce_xor(input logic [N_INPUTS-1:0] v, input logic [N_INPUTS-1:0] m);
    return ^(v & m);
  endfunction

  function automatic logic gate_eval(input logic [2:0] mode, input logic [N_INPUTS-1:0] v);
    logic r;
    case (mode)
      3'b000:  r = reduce_and(v, FULL_MASK);
      3'b001:  r = reduce_or(v, FULL_MASK);
      3'b010:  r = ~reduce_and(v, FULL_MASK);
      3'b011:  r = ~reduce_or(v, FULL_MASK);
      3'b100:  r = reduce_xor(v, FULL_MASK);
      3'b101:  r = ~reduce_xor(v, FULL_MASK);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // First stage covers all but the top input and is never inverted.
  function automatic logic stage1_eval(input logic [2:0] mode, input logic [N_INPUTS-1:0] v);
    logic r;
    case (mode)
      3'b000, 3'b010: r = reduce_and(v, STAGE_MASK);
      3'b001, 3'b011: r = reduce_or(v, STAGE_MASK);
      3'b100, 3'b101: r = reduce_xor(v, STAGE_MASK);
      default:        r = 1'b0;
    endcase
    return r;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < RESULT_W; gi++) begin : g_table
      assign table_vec[gi] = gate_eval(mode_reg, N_INPUTS'(gi));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = SWEEP;
      SWEEP:   if (idx_reg == LAST_IDX) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      mode_reg   <= 3'b000;
      result_reg <= '0;
      gate_reg   <= 1'b0;
      stage1_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      gate_reg   <= gate_eval(bus.gateMode, bus.manualIn);
      stage1_reg <= stage1_eval(bus.gateMode, bus.manualIn);
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            mode_reg   <= bus.gateMode;
            result_reg <= '0;
            idx_reg    <= '0;
          end
        end
        SWEEP: begin
          result_reg[idx_reg[N_INPUTS-1:0]] <= table_vec[idx_reg[N_INPUTS-1:0]];
          if (idx_reg != LAST_IDX) idx_reg <= idx_reg + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef ONES_COUNT_EN
  logic [N_INPUTS:0] count_reg;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_reg <= '0;
    end else if (state_reg == IDLE && bus.start) begin
      count_reg <= '0;
    end else if (state_reg == SWEEP) begin
      count_reg <= count_reg + {{N_INPUTS{1'b0}}, table_vec[idx_reg[N_INPUTS-1:0]]};
    end
  end

  assign bus.onesCount = count_reg;
`else
  assign bus.onesCount = '0;
`endif

  assign bus.busy      = (state_reg == SWEEP);
  assign bus.done      = (state_reg == DONE);
  assign bus.sweepIn   = (state_reg == SWEEP) ? idx_reg[N_INPUTS-1:0] : '0;
  assign bus.result    = result_reg;
  assign bus.gateOut   = gate_reg;
  assign bus.stage1Out = stage1_reg;
endmodule

// File: tb/tb_logic_gate_sweeper.sv
// Randomised and directed checks of logic_gate_sweeper against a popcount-based
// reference that derives sweep timing from the start edge number.
module tb_logic_gate_sweeper;
  localparam int N  = 3;
  localparam int RW = 1 << N;

  logic clk;
  logic resetN;
  logic chk_en;
  int   errors;
  int   checks;

  logic_gate_sweeper_if #(.N_INPUTS(N)) bus_if ();

  logic_gate_sweeper #(.N_INPUTS(N)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int popc(input logic [7:0] v, input int w);
    int p = 0;
    for (int i = 0; i < w; i++) p += int'(v[i]);
    return p;
  endfunction

  function automatic logic ref_gate(input logic [2:0] m, input logic [7:0] v, input int w);
    int p = popc(v, w);
    case (m)
      3'd0:    return p == w;
      3'd1:    return p > 0;
      3'd2:    return p != w;
      3'd3:    return p == 0;
      3'd4:    return (p % 2) == 1;
      3'd5:    return (p % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic ref_stage1(input logic [2:0] m, input logic [7:0] v);
    case (m)
      3'd0, 3'd2: return ref_gate(3'd0, v, N - 1);
      3'd1, 3'd3: return ref_gate(3'd1, v, N - 1);
      3'd4, 3'd5: return ref_gate(3'd4, v, N - 1);
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] ref_table(input logic [2:0] m);
    logic [7:0] t = '0;
    for (int k = 0; k < RW; k++) t[k] = ref_gate(m, 8'(k), N);
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference state: edge counter and the edge at which the last sweep was accepted.
  int         edge_n;
  int         sweep_e;
  logic [2:0] m_mode;
  logic       exp_gate;
  logic       exp_stage1;

  always @(posedge clk or negedge resetN) begin : model
    int n;
    if (!resetN) begin
      sweep_e    <= -1;
      exp_gate   <= 1'b0;
      exp_stage1 <= 1'b0;
    end else begin
      n = edge_n + 1;
      edge_n     <= n;
      exp_gate   <= ref_gate(bus_if.gateMode, 8'(bus_if.manualIn), N);
      exp_stage1 <= ref_stage1(bus_if.gateMode, 8'(bus_if.manualIn));
      if (bus_if.start && (sweep_e < 0 || n >= sweep_e + RW + 2)) begin
        sweep_e <= n;
        m_mode  <= bus_if.gateMode;
      end
    end
  end

  always @(negedge clk) begin : compare
    int         d;
    int         nb;
    int         eo;
    logic [7:0] tbl;
    logic [7:0] er;
    logic       eb;
    logic       ed;
    logic [2:0] esw;
    if (chk_en) begin
      d   = edge_n - sweep_e;
      tbl = ref_table(m_mode);
      nb  = 0;
      eb  = 1'b0;
      ed  = 1'b0;
      esw = '0;
      if (sweep_e >= 0) begin
        eb = (d >= 0) && (d < RW);
        ed = (d == RW);
        nb = (d < RW) ? d : RW;
        if (eb) esw = 3'(d);
      end
      er = '0;
      for (int k = 0; k < nb; k++) er[k] = tbl[k];
`ifdef ONES_COUNT_EN
      eo = popc(er, RW);
`else
      eo = 0;
`endif
      chk("busy",      32'(bus_if.busy),      32'(eb));
      chk("done",      32'(bus_if.done),      32'(ed));
      chk("sweepIn",   32'(bus_if.sweepIn),   32'(esw));
      chk("result",    32'(bus_if.result),    32'(er));
      chk("onesCount", 32'(bus_if.onesCount), 32'(eo));
      chk("gateOut",   32'(bus_if.gateOut),   32'(exp_gate));
      chk("stage1Out", 32'(bus_if.stage1Out), 32'(exp_stage1));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_sweep(input string name, input logic [2:0] m, input logic [7:0] exp_r, input int exp_ones);
    int cnt = 0;
    bus_if.gateMode = m;
    bus_if.start    = 1'b1;
    step();
    bus_if.start = 1'b0;
    while (cnt <= 30) begin
      @(negedge clk);
      cnt++;
      if (bus_if.done) break;
    end
    $display("sweep %s mode=%0d result=%b done_after=%0d", name, m, bus_if.result, cnt);
    chk({name, "_latency"}, 32'(cnt), 32'd9);
    chk({name, "_result"}, 32'(bus_if.result), 32'(exp_r));
`ifdef ONES_COUNT_EN
    chk({name, "_ones"}, 32'(bus_if.onesCount), 32'(exp_ones));
`else
    chk({name, "_ones"}, 32'(bus_if.onesCount), 32'd0);
`endif
    step();
  endtask

  initial begin
    int dones;
    errors = 0;
    checks = 0;
    edge_n = 0;
    chk_en = 1'b0;
    bus_if.gateMode = 3'b000;
    bus_if.manualIn = '0;
    bus_if.start    = 1'b0;
    resetN = 1'b1;
    #1 resetN = 1'b0;
    chk_en = 1'b1;
    repeat (2) step();
    chk("reset_gate",   32'(bus_if.gateOut), 32'd0);
    chk("reset_result", 32'(bus_if.result),  32'd0);
    chk("reset_busy",   32'(bus_if.busy),    32'd0);
    resetN = 1'b1;

    bus_if.manualIn = 3'b111;
    bus_if.gateMode = 3'b000;
    step();
    $display("manual and 111: gateOut=%b stage1Out=%b", bus_if.gateOut, bus_if.stage1Out);
    chk("manual_gate",   32'(bus_if.gateOut),   32'd1);
    chk("manual_stage1", 32'(bus_if.stage1Out), 32'd1);

    run_sweep("and", 3'b000, 8'b1000_0000, 1);
    run_sweep("xor", 3'b100, 8'b1001_0110, 4);
    run_sweep("nor", 3'b011, 8'b0000_0001, 1);

    // Mode change and a second start while busy must not disturb the sweep.
    bus_if.gateMode = 3'b000;
    bus_if.start = 1'b1;
    step();
    bus_if.start = 1'b0;
    repeat (3) step();
    bus_if.gateMode = 3'b001;
    bus_if.start = 1'b1;
    step();
    bus_if.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_if.done) dones++;
    end
    $display("busy-start sweep: result=%b dones=%0d", bus_if.result, dones);
    chk("busy_start_dones",  32'(dones),         32'd1);
    chk("busy_start_result", 32'(bus_if.result), 32'h80);

    // Reset in the middle of a sweep.
    step();
    bus_if.start = 1'b1;
    step();
    bus_if.start = 1'b0;
    repeat (3) step();
    resetN = 1'b0;
    #1;
    $display("mid-sweep reset: result=%b busy=%b done=%b", bus_if.result, bus_if.busy, bus_if.done);
    chk("midreset_result", 32'(bus_if.result), 32'd0);
    chk("midreset_busy",   32'(bus_if.busy),   32'd0);
    chk("midreset_done",   32'(bus_if.done),   32'd0);
    repeat (2) step();
    resetN = 1'b1;
    step();
    run_sweep("or", 3'b001, 8'b1111_1110, 7);

    bus_if.gateMode = 3'b110;
    bus_if.manualIn = 3'b111;
    step();
    $display("reserved manual: gateOut=%b", bus_if.gateOut);
    chk("reserved_gate", 32'(bus_if.gateOut), 32'd0);
    run_sweep("reserved", 3'b110, 8'h00, 0);

    // start held high: back-to-back sweeps with one idle cycle between.
    bus_if.gateMode = 3'(($urandom_range(0, 5)));
    bus_if.start = 1'b1;
    repeat (25) step();
    bus_if.start = 1'b0;
    repeat (12) step();
    $display("held start done, result=%b", bus_if.result);

    for (int i = 0; i < 400; i++) begin
      bus_if.manualIn = 3'($urandom_range(0, 7));
      bus_if.gateMode = 3'($urandom_range(0, 7));
      bus_if.start    = ($urandom_range(0, 3) == 0);
      resetN          = ($urandom_range(0, 149) != 0);
      step();
    end
    resetN = 1'b1;
    bus_if.start = 1'b0;
    repeat (12) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/logic_gate_sweeper.md
# logic_gate_sweeper

- Parametrised N-input logic-gate evaluator with a run-time-selectable gate mode.
- Manual mode: a registered gate output for switch-driven inputs.
- Sweep mode: a built-in sequencer walks all 2^N input combinations and captures the gate's full truth table into a result vector.
- Sits between the board switches/buttons and the LED bank as the general lab gate unit.

## Interface
- N_INPUTS, default 3: gate input count, legal 2..6; RESULT_W = 2^N_INPUTS is a local derived width.
- clk  input  1  system clock, rising edge.
- resetN  input  1  asynchronous, active-low reset.
- gateMode  input  3  000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110/111 reserved (evaluate to 0).
- manualIn  input  N_INPUTS  switch inputs for manual evaluation.
- start  input  1  sweep request, sampled high for one cycle in IDLE.
- busy  output  1  high while a sweep is running.
- done  output  1  one-cycle pulse on sweep completion.
- sweepIn  output  N_INPUTS  input vector currently applied by the sequencer.
- stage1Out  output  1  registered first-stage partial: the same base function (AND/OR/XOR) over manualIn[N_INPUTS-2:0], never inverted.
- gateOut  output  1  registered full gate result over manualIn.
- result  output  RESULT_W  truth table; bit k = gate(k).
- onesCount  output  N_INPUTS+1  number of 1s in result (see Configuration).

## Operation
- Gate function: the base op is AND (000/010), OR (001/011) or XOR (100/101), reduced over all inputs; NAND/NOR/XNOR invert the final result only.
- Reserved modes give 0 on gateOut, stage1Out and every result bit.
- stage1Out and gateOut:
  - updated every cycle in every state from manualIn and the live gateMode;
  - not affected by sweeping.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE: start=1 → SWEEP. Latch gateMode into modeLat, clear result and onesCount, set idx to 0.
  - SWEEP: each cycle write result[idx] = gate(modeLat, idx), add it to onesCount, and present sweepIn = idx.
    - If idx == RESULT_W-1 → DONE.
    - Otherwise idx increments by 1.
  - DONE: assert done for one cycle, then → IDLE.
- start outside IDLE is ignored; it is not queued.
- gateMode changes during SWEEP do not affect the sweep in progress.
- result and onesCount hold their values after DONE until the next start.
- idx is N_INPUTS+1 bits wide internally, so the last compare cannot wrap; sweepIn is its low N_INPUTS bits.

## Timing
- Reset values: busy 0, done 0, sweepIn 0, stage1Out 0, gateOut 0, result 0, onesCount 0; state IDLE.
- Manual latency: gateOut and stage1Out reflect manualIn/gateMode after 1 clk edge.
- Sweep, with start sampled at edge E:
  - busy rises after E.
  - result[k] is written at edge E+1+k.
  - done is high for the cycle following edge E+RESULT_W.
  - busy falls at that same edge.
- Total sweep time: RESULT_W+1 cycles from start to done; 9 cycles for N_INPUTS=3.
- Reset mid-sweep:
  - all outputs return immediately to their reset values;
  - the partial result is discarded;
  - no done pulse is produced.
- start held high continuously: a new sweep begins on the first IDLE cycle after done, so sweeps repeat back-to-back with one idle cycle between them.

## Configuration
- ONES_COUNT_EN defined:
  - onesCount accumulates during SWEEP as above.
  - It is final in the done cycle.
- ONES_COUNT_EN undefined:
  - onesCount is tied to 0.
  - No counter logic is synthesised.
  - All other behaviour is identical.

## Test plan
- Reset, N_INPUTS=3: resetN=0 → every output 0; release, manualIn=3'b111, gateMode=000 → gateOut=1 and stage1Out=1 one edge later.
- AND sweep: gateMode=000, start pulse → result=8'b1000_0000 with done exactly 9 cycles after start; onesCount=1 with ONES_COUNT_EN.
- XOR then NOR: gateMode=100 → result=8'b1001_0110 (onesCount=4); gateMode=011 → result=8'b0000_0001.
- Mode change and start during busy: switch gateMode to 001 mid-AND-sweep and pulse start → result still 8'b1000_0000; a single done pulse only.
- Reset mid-sweep: assert resetN=0 at sweep cycle 4 → result=0, busy=0, no done; a fresh OR sweep afterwards gives 8'b1111_1110.
- Reserved mode 110: manualIn=3'b111 → gateOut=0; sweep → result=8'h00, done after 9 cycles.
